// File: rtl/spwtcr_link_fsm_if.sv
// Host/datapath-facing signal bundle of the SpaceWire link-interface state machine.
// master: the link FSM; slave: the host registers and TX/RX datapaths around it.
interface spwtcr_link_fsm_if;
  logic       link_start;
  logic       link_disable;
  logic       auto_start;
  logic       got_null;
  logic       got_fct;
  logic       got_nchar;
  logic       got_time_code;
  logic       rx_error;
  logic       credit_error;
  logic       rx_resetn;
  logic       tx_enable;
  logic       fct_enable;
  logic       data_enable;
  logic [2:0] link_state;
  logic       link_up;
  logic       link_error;

  modport master (
    input  link_start, link_disable, auto_start, got_null, got_fct, got_nchar, got_time_code,
    input  rx_error, credit_error,
    output rx_resetn, tx_enable, fct_enable, data_enable, link_state, link_up, link_error
  );

  modport slave (
    output link_start, link_disable, auto_start, got_null, got_fct, got_nchar, got_time_code,
    output rx_error, credit_error,
    input  rx_resetn, tx_enable, fct_enable, data_enable, link_state, link_up, link_error
  );
endinterface

// File: rtl/spwtcr_link_fsm.sv
// SpaceWire link-interface state machine: sequences RX reset and TX permissions through
// ErrorReset/ErrorWait/Ready/Started/Connecting/Run with the 6.4 us and 12.8 us intervals.
module spwtcr_link_fsm #(
  parameter int unsigned TICKS_6U4  = 64,
  parameter int unsigned TICKS_12U8 = 128
) (
  input logic               CLOCK,
  input logic               RESETn,
  spwtcr_link_fsm_if.master link
);

  localparam int unsigned TW = $clog2(TICKS_12U8 + 1);
  // Timer counts 0..N-1 inside a timed state, so a state lasts exactly N cycles.
  localparam logic [TW-1:0] Last6u4  = TW'(TICKS_6U4 - 1);
  localparam logic [TW-1:0] Last12u8 = TW'(TICKS_12U8 - 1);
  localparam logic [TW-1:0] TimerMax = TW'(TICKS_12U8);

  typedef enum logic [2:0] {
    StErrorReset = 3'd0,
    StErrorWait  = 3'd1,
    StReady      = 3'd2,
    StStarted    = 3'd3,
    StConnecting = 3'd4,
    StRun        = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic          rx_resetn_q, tx_enable_q, fct_enable_q, data_enable_q, link_up_q, link_error_q;
  logic          bad_char, link_enabled;

  always_comb begin
    bad_char     = link.got_fct | link.got_nchar | link.got_time_code;
    link_enabled = !link.link_disable & (link.link_start | (link.auto_start & link.got_null));
    state_d      = state_q;
    case (state_q)
      StErrorReset: begin
        if (timer_q == Last6u4) state_d = StErrorWait;
      end
      StErrorWait: begin
        if (link.rx_error || bad_char)  state_d = StErrorReset;
        else if (timer_q == Last12u8)   state_d = StReady;
      end
      StReady: begin
        if (link.rx_error || bad_char)  state_d = StErrorReset;
        else if (link_enabled)          state_d = StStarted;
      end
      StStarted: begin
        if (link.rx_error || bad_char)  state_d = StErrorReset;
        else if (link.got_null)         state_d = StConnecting;
        else if (timer_q == Last12u8)   state_d = StErrorReset;
      end
      StConnecting: begin
        // A coincident FCT does not rescue a cycle that also carries an error.
        if (link.rx_error || link.got_nchar || link.got_time_code) state_d = StErrorReset;
        else if (link.got_fct)          state_d = StRun;
        else if (timer_q == Last12u8)   state_d = StErrorReset;
      end
      StRun: begin
        if (link.rx_error || link.credit_error || link.link_disable) state_d = StErrorReset;
      end
      default: state_d = StErrorReset;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= StErrorReset;
      timer_q       <= '0;
      rx_resetn_q   <= 1'b0;
      tx_enable_q   <= 1'b0;
      fct_enable_q  <= 1'b0;
      data_enable_q <= 1'b0;
      link_up_q     <= 1'b0;
      link_error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)     timer_q <= '0;
      else if (timer_q != TimerMax) timer_q <= timer_q + TW'(1);
      rx_resetn_q   <= (state_d != StErrorReset);
      tx_enable_q   <= (state_d == StStarted) || (state_d == StConnecting) || (state_d == StRun);
      fct_enable_q  <= (state_d == StConnecting) || (state_d == StRun);
      data_enable_q <= (state_d == StRun);
      link_up_q     <= (state_d == StRun);
      link_error_q  <= (state_q == StRun) && (state_d == StErrorReset);
    end
  end

  assign link.link_state  = state_q;
  assign link.rx_resetn   = rx_resetn_q;
  assign link.tx_enable   = tx_enable_q;
  assign link.fct_enable  = fct_enable_q;
  assign link.data_enable = data_enable_q;
  assign link.link_up     = link_up_q;
  assign link.link_error  = link_error_q;

endmodule
